// File: rtl/adc_spi_responder.sv
// SPI responder emulating an AD7928-class ADC: returns {0, channel, sample} per 16-bit frame
// and accepts a control word whose WRITE bit updates ctrl_reg and the next frame's channel.
module adc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        ADC_CS_N,
  input  logic        ADC_SCLK,
  input  logic        ADC_DIN,
  output logic        ADC_DOUT,
  input  logic [11:0] sample_in,
  output logic [2:0]  sample_ch,
  output logic [11:0] ctrl_reg,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StWaitHigh
  } state_e;

  localparam logic [1:0] SettleMax = 2'(SYNC_STAGES);
  localparam logic [4:0] CntFull   = 5'd16;
  localparam logic [4:0] CntSat    = 5'd17;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, din_s;
  logic                   sclk_fall, cs_fall, cs_rise;

  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  settle_q, settle_d;
  logic        dout_q, dout_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic [2:0]  ch_q, ch_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  always_ff @(posedge CLK) begin
    if (reset) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      din_sync_q  <= '1;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      state_q     <= StWaitHigh;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      dout_q      <= 1'b0;
      ctrl_q      <= '0;
      ch_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], ADC_DIN};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      dout_q      <= dout_d;
      ctrl_q      <= ctrl_d;
      ch_q        <= ch_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    dout_d   = dout_q;
    ctrl_d   = ctrl_q;
    ch_d     = ch_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      // The synchronizers come out of reset holding 1; only trust cs_s once they have
      // flushed, otherwise a frame interrupted by reset would look like a fresh CS_N fall.
      StWaitHigh: begin
        dout_d = 1'b0;
        if (settle_q != SettleMax) begin
          settle_d = settle_q + 2'd1;
        end else if (cs_s) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        dout_d = 1'b0;
        if (cs_fall) begin
          state_d = StActive;
          tx_d    = {1'b0, ch_q, sample_in};
          rx_d    = '0;
          cnt_d   = '0;
          dout_d  = 1'b0;
        end
      end

      StActive: begin
        // CS_N rise takes priority over a coincident SCLK fall.
        if (cs_rise) begin
          state_d = StIdle;
          dout_d  = 1'b0;
          if (cnt_q == CntFull) begin
            done_d = 1'b1;
            if (rx_q[15]) begin
              ctrl_d = rx_q[15:4];
              ch_d   = rx_q[12:10];
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + 5'd1;
          end
          if (cnt_q < CntFull) begin
            rx_d = {rx_q[14:0], din_s};
          end
          tx_d   = {tx_q[14:0], 1'b0};
          dout_d = tx_q[14];
        end
      end

      default: begin
        state_d = StWaitHigh;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign ADC_DOUT   = dout_q;
  assign sample_ch  = ch_q;
  assign ctrl_reg   = ctrl_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == StActive);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: table of frames plus reset-mid-frame and
// CS/SCLK collision sequences.
module tb_adc_spi_responder;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        ADC_CS_N = 1'b1;
  logic        ADC_SCLK = 1'b1;
  logic        ADC_DIN = 1'b0;
  logic        ADC_DOUT;
  logic [11:0] sample_in = '0;
  logic [2:0]  sample_ch;
  logic [11:0] ctrl_reg;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  adc_spi_responder #(
    .SYNC_STAGES(2)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .ADC_CS_N  (ADC_CS_N),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_DIN   (ADC_DIN),
    .ADC_DOUT  (ADC_DOUT),
    .sample_in (sample_in),
    .sample_ch (sample_ch),
    .ctrl_reg  (ctrl_reg),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Pulse counters; a pulse wider than one CLK shows up as a count of 2 or more.
  always @(posedge CLK) begin
    #1;
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  typedef struct {
    logic [15:0] din;
    int          n;
    logic [11:0] smp;
    bit          clash;
    logic [15:0] exp_dout;
    bit          exp_done;
    logic [11:0] exp_ctrl;
    logic [2:0]  exp_ch;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One frame: n SCLK falling edges, DOUT captured just before each of the first 16.
  task automatic run_frame(input logic [15:0] din_w, input int n, input logic [11:0] smp,
                           input bit clash, input string tag, output logic [15:0] cap);
    cap = '0;
    sample_in = smp;
    ADC_CS_N = 1'b0;
    clk_wait(8);
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      ADC_DIN = (i < 16) ? din_w[15-i] : 1'b0;
      clk_wait(4);
      if (i < 16) cap[15-i] = ADC_DOUT;
      ADC_SCLK = 1'b0;
      if (clash && i == n - 1) ADC_CS_N = 1'b1;
      clk_wait(4);
      ADC_SCLK = 1'b1;
    end
    if (!clash) begin
      clk_wait(4);
      if (n >= 16) check({tag, " dout_after16"}, 32'(ADC_DOUT), 32'd0);
      ADC_CS_N = 1'b1;
    end
    clk_wait(8);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
    check({tag, " dout_end"}, 32'(ADC_DOUT), 32'd0);
  endtask

  initial begin
    logic [15:0] cap;
    logic [15:0] mask;
    int          nb;
    int          d0;
    int          e0;
    logic        dout_seen;

    //         din       n   smp     clash exp_dout  done ctrl     ch
    vecs[0] = '{16'h0000, 16, 12'hA5C, 1'b0, 16'h0A5C, 1'b1, 12'h000, 3'd0};
    vecs[1] = '{16'h9C00, 16, 12'h000, 1'b0, 16'h0000, 1'b1, 12'h9C0, 3'd7};
    vecs[2] = '{16'h0000, 16, 12'h123, 1'b0, 16'h7123, 1'b1, 12'h9C0, 3'd7};
    vecs[3] = '{16'h8400, 16, 12'hFFF, 1'b0, 16'h7FFF, 1'b1, 12'h840, 3'd1};
    vecs[4] = '{16'hFFFF, 10, 12'h3C3, 1'b0, 16'h13C3, 1'b0, 12'h840, 3'd1};
    vecs[5] = '{16'h0000, 17, 12'h555, 1'b0, 16'h1555, 1'b0, 12'h840, 3'd1};
    vecs[6] = '{16'h0000, 16, 12'h0AA, 1'b0, 16'h10AA, 1'b1, 12'h840, 3'd1};
    vecs[7] = '{16'hFFFF, 0,  12'h777, 1'b0, 16'h0000, 1'b0, 12'h840, 3'd1};
    vecs[8] = '{16'hA800, 16, 12'h800, 1'b0, 16'h1800, 1'b1, 12'hA80, 3'd2};
    vecs[9] = '{16'hFC00, 16, 12'h0F0, 1'b1, 16'h20F0, 1'b0, 12'hA80, 3'd2};

    // Reset state
    clk_wait(4);
    check("rst dout", 32'(ADC_DOUT), 32'd0);
    check("rst ch", 32'(sample_ch), 32'd0);
    check("rst ctrl", 32'(ctrl_reg), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst err", 32'(frame_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    clk_wait(10);
    check("post_rst busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vecs[i].din, vecs[i].n, vecs[i].smp, vecs[i].clash, tag, cap);
      nb = (vecs[i].n > 16) ? 16 : vecs[i].n;
      mask = 16'hFFFF << (16 - nb);
      if (nb > 0) check({tag, " dout_word"}, 32'(cap & mask), 32'(vecs[i].exp_dout & mask));
      check({tag, " done"}, 32'(done_cnt - d0), vecs[i].exp_done ? 32'd1 : 32'd0);
      check({tag, " err"}, 32'(err_cnt - e0), vecs[i].exp_done ? 32'd0 : 32'd1);
      check({tag, " ctrl"}, 32'(ctrl_reg), 32'(vecs[i].exp_ctrl));
      check({tag, " ch"}, 32'(sample_ch), 32'(vecs[i].exp_ch));
    end

    // Reset pulse mid-frame after edge 7, CS_N kept low through the remaining edges.
    d0 = done_cnt;
    e0 = err_cnt;
    dout_seen = 1'b0;
    sample_in = 12'hFFF;
    ADC_CS_N = 1'b0;
    clk_wait(8);
    for (int i = 0; i < 16; i++) begin
      ADC_DIN = 1'b1;
      clk_wait(4);
      if (i >= 8) dout_seen = dout_seen | ADC_DOUT;
      ADC_SCLK = 1'b0;
      clk_wait(2);
      if (i == 6) begin
        reset = 1'b1;
        clk_wait(1);
        reset = 1'b0;
        clk_wait(1);
      end else begin
        clk_wait(2);
      end
      ADC_SCLK = 1'b1;
    end
    clk_wait(4);
    check("mid_rst dout_low", 32'(dout_seen | ADC_DOUT), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    ADC_CS_N = 1'b1;
    clk_wait(8);
    check("mid_rst done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst err", 32'(err_cnt - e0), 32'd0);
    check("mid_rst ctrl", 32'(ctrl_reg), 32'd0);
    check("mid_rst ch", 32'(sample_ch), 32'd0);

    d0 = done_cnt;
    run_frame(16'h9C00, 16, 12'h321, 1'b0, "after_rst", cap);
    check("after_rst dout_word", 32'(cap), 32'h0321);
    check("after_rst done", 32'(done_cnt - d0), 32'd1);
    check("after_rst ctrl", 32'(ctrl_reg), 32'h9C0);
    check("after_rst ch", 32'(sample_ch), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ADC_SCLK, ADC_CS_N and ADC_DIN; legal values 2..3.
REQ-002 SHALL have port CLK, input, 1: single system clock (50 MHz); every flop is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ADC_CS_N, input, 1: frame select from the ADC controller, active low, asynchronous to CLK.
REQ-005 SHALL have port ADC_SCLK, input, 1: serial clock from the controller, idles high, asynchronous to CLK.
REQ-006 SHALL have port ADC_DIN, input, 1: control bits from the controller, MSB first.
REQ-007 SHALL have port ADC_DOUT, output, 1: conversion result to the controller, MSB first.
REQ-008 SHALL have port sample_in, input, 12: unsigned sample for the channel on sample_ch, supplied by the stimulus source.
REQ-009 SHALL have port sample_ch, output, 3: channel the current frame reports, held stable between frames.
REQ-010 SHALL have port ctrl_reg, output, 12: last accepted control word, DIN frame bits [15:4].
REQ-011 SHALL have port frame_done, output, 1: one-CLK pulse marking a completed 16-bit frame.
REQ-012 SHALL have port frame_err, output, 1: one-CLK pulse marking a malformed frame.
REQ-013 SHALL have port busy, output, 1: high while a frame is in progress.

Function
REQ-014 SHALL pass ADC_SCLK, ADC_CS_N and ADC_DIN through SYNC_STAGES flops each; all edge detection SHALL use the synchronized copies (SCLK falling edge = previous 1, current 0).
REQ-015 SHALL implement states IDLE, ACTIVE and WAIT_HIGH.
REQ-016 IDLE -> ACTIVE SHALL occur on a synchronized CS_N falling edge; at the same time the block SHALL latch {1'b0, sample_ch, sample_in} into a 16-bit tx shift register, drive bit15 (0) on ADC_DOUT, clear the edge counter, and assert busy.
REQ-017 In ACTIVE, each synchronized SCLK falling edge SHALL shift the synchronized DIN into rx_shift[0] (rx shifts left) and advance tx so ADC_DOUT presents the next bit; after the 16th edge ADC_DOUT SHALL be 0.
REQ-018 Edge counter SHALL be 5 bits and saturate at 17; falling edges beyond 16 SHALL NOT shift rx.
REQ-019 A synchronized CS_N rising edge in ACTIVE SHALL return to IDLE, clear busy, and set ADC_DOUT to 0 in the same CLK.
REQ-020 At that CS_N rise, count==16 SHALL pulse frame_done; any other count (including 0 and 17) SHALL pulse frame_err and change no register.
REQ-021 On frame_done with rx_shift[15] (WRITE)=1, ctrl_reg SHALL load rx_shift[15:4] and sample_ch SHALL load rx_shift[12:10] on the same CLK as the frame_done pulse; with WRITE=0 both SHALL hold.
REQ-022 A new sample_ch SHALL take effect from the next frame only (one-frame pipeline, as in AD7928-class converters).
REQ-023 When a CS_N rise and an SCLK falling edge are detected in the same CLK, the CS_N rise SHALL win and the edge SHALL be discarded.
REQ-024 ADC_DOUT SHALL update within SYNC_STAGES+1 CLK of the SCLK pin falling edge; correct operation requires SCLK high and low phases of at least SYNC_STAGES+2 CLK each.
REQ-025 ADC_DOUT SHALL be 0 whenever the state is not ACTIVE (no tri-state).

Reset
REQ-026 While reset is high: state=WAIT_HIGH, ADC_DOUT=0, sample_ch=0, ctrl_reg=0, frame_done=0, frame_err=0, busy=0, counter and shift registers=0, synchronizer flops=1.
REQ-027 WAIT_HIGH SHALL move to IDLE only after a synchronized CS_N high is sampled, so a reset mid-frame SHALL discard that frame silently, with no frame_done and no frame_err.

Verification
REQ-028 Reset release, CS_N low, sample_in=12'hA5C, DIN=16'h0000, 16 SCLK cycles (8 CLK each) -> DOUT word 16'h0A5C, frame_done=1 for one CLK, sample_ch stays 0.
REQ-029 Frame 1 DIN=16'h9C00 (WRITE=1, ADD=3'b111) -> after frame, ctrl_reg=12'h9C0, sample_ch=7; frame 2 with sample_in=12'h123 -> DOUT=16'h7123.
REQ-030 CS_N raised after 10 SCLK edges -> frame_err pulse, ctrl_reg and sample_ch unchanged, busy=0, DOUT=0.
REQ-031 17 SCLK edges in one frame -> frame_err; the following 16-edge frame -> frame_done.
REQ-032 reset asserted for 1 CLK after edge 7 while CS_N is held low -> no pulses, DOUT=0; next full frame after CS_N high decodes correctly.
REQ-033 CS_N rise and SCLK fall arranged to land in the same synchronized CLK at edge 16 -> edge discarded, count=15, frame_err.
